// File: rtl/mem_bank_pkg.sv
// Shared types and helpers for the memory bank select controller.
package mem_bank_pkg;

    localparam int unsigned BANK_W_MAX = 16;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_INC  = 3'd2,
        OP_DEC  = 3'd3,
        OP_PUSH = 3'd4,
        OP_POP  = 3'd5
    } bank_op_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } bank_dir_e;

    // Step one bank up or down, wrapping at max_bank rather than at the field width.
    function automatic logic [BANK_W_MAX-1:0] wrap_bank(
        input logic [BANK_W_MAX-1:0] cur,
        input logic [BANK_W_MAX-1:0] max_bank,
        input bank_dir_e             dir
    );
        if (dir == DIR_UP) begin
            return (cur == max_bank) ? '0 : cur + BANK_W_MAX'(1);
        end
        return (cur == '0) ? max_bank : cur - BANK_W_MAX'(1);
    endfunction

endpackage

// File: rtl/mem_bank_ctrl_if.sv
// Control/status bundle between the control unit and the bank select controller.
interface mem_bank_ctrl_if #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
);
    import mem_bank_pkg::*;

    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic             ce;
    bank_op_e         op;
    logic [WIDTH-1:0] new_bank;
    logic             err_clr;
    logic [WIDTH-1:0] bank;
    logic [LVL_W-1:0] level;
    logic             stack_full;
    logic             stack_empty;
    logic             err;

    modport master (
        output ce, op, new_bank, err_clr,
        input  bank, level, stack_full, stack_empty, err
    );

    modport slave (
        input  ce, op, new_bank, err_clr,
        output bank, level, stack_full, stack_empty, err
    );

endinterface

// File: rtl/mem_bank_lifo.sv
// Register-array LIFO holding saved bank context; top entry is always visible on dout.
module mem_bank_lifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LVL_W-1:0] level_q;

    // Contents need no reset: only entries below level are ever read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[IDX_W'(level_q)] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else if (push && !full) begin
            level_q <= level_q + LVL_W'(1);
        end else if (pop && !empty) begin
            level_q <= level_q - LVL_W'(1);
        end
    end

    assign dout  = mem[IDX_W'(level_q - LVL_W'(1))];
    assign level = level_q;
    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);

endmodule

// File: rtl/mem_bank_ctrl.sv
// Current bank select for the CPU data path with wrap stepping, range check,
// save/restore stack and a sticky error flag for illegal requests.
module mem_bank_ctrl
    import mem_bank_pkg::*;
#(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned MAX_BANK = 2**WIDTH - 1,
    parameter int unsigned DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    mem_bank_ctrl_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_B = WIDTH'(MAX_BANK);

    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] bank_nxt;
    logic             err_q;
    logic             set_err;
    logic             push;
    logic             pop;
    logic             new_legal;
    logic [WIDTH-1:0] lifo_top;
    logic             lifo_full;
    logic             lifo_empty;

    assign new_legal = (bus.new_bank <= MAX_B);

    // Op decode and legality: an illegal op changes nothing but the error flag.
    always_comb begin
        bank_nxt = bank_q;
        set_err  = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        if (bus.ce) begin
            case (bus.op)
                OP_NOP: ;
                OP_LOAD: begin
                    if (new_legal) bank_nxt = bus.new_bank;
                    else           set_err  = 1'b1;
                end
                OP_INC:  bank_nxt = WIDTH'(wrap_bank(BANK_W_MAX'(bank_q), BANK_W_MAX'(MAX_B), DIR_UP));
                OP_DEC:  bank_nxt = WIDTH'(wrap_bank(BANK_W_MAX'(bank_q), BANK_W_MAX'(MAX_B), DIR_DOWN));
                OP_PUSH: begin
                    if (!lifo_full && new_legal) begin
                        push     = 1'b1;
                        bank_nxt = bus.new_bank;
                    end else begin
                        set_err  = 1'b1;
                    end
                end
                OP_POP: begin
                    if (!lifo_empty) begin
                        pop      = 1'b1;
                        bank_nxt = lifo_top;
                    end else begin
                        set_err  = 1'b1;
                    end
                end
                default: set_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q <= '0;
        end else begin
            bank_q <= bank_nxt;
        end
    end

    // A new error in the same cycle as a clear must not be lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (set_err) begin
            err_q <= 1'b1;
        end else if (bus.err_clr) begin
            err_q <= 1'b0;
        end
    end

    mem_bank_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bank_q),
        .dout  (lifo_top),
        .level (bus.level),
        .full  (lifo_full),
        .empty (lifo_empty)
    );

    assign bus.bank        = bank_q;
    assign bus.err         = err_q;
    assign bus.stack_full  = lifo_full;
    assign bus.stack_empty = lifo_empty;

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Scoreboard bench for mem_bank_ctrl with WIDTH=2, MAX_BANK=2, DEPTH=2.
module tb_mem_bank_ctrl;
    import mem_bank_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct {
        int         due;
        string      name;
        logic [1:0] bank;
        logic [1:0] level;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    mem_bank_ctrl_if #(.WIDTH(2), .DEPTH(2)) bus ();

    mem_bank_ctrl #(
        .WIDTH    (2),
        .MAX_BANK (2),
        .DEPTH    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input string what, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d", name, what, act, want);
        end
    endfunction

    function automatic void chk_all(input string name, input logic [1:0] b, input logic [1:0] l, input logic e);
        chk(name, "bank",  int'(bus.bank),        int'(b));
        chk(name, "level", int'(bus.level),       int'(l));
        chk(name, "full",  int'(bus.stack_full),  int'(l == 2'd2));
        chk(name, "empty", int'(bus.stack_empty), int'(l == 2'd0));
        chk(name, "err",   int'(bus.err),         int'(e));
    endfunction

    // Monitor: results are due one edge after the vector was sampled.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk_all(e.name, e.bank, e.level, e.err);
        end
    end

    task automatic step(input string name, input logic ce, input logic [2:0] op,
                        input logic [1:0] nb, input logic clr,
                        input logic [1:0] eb, input logic [1:0] el, input logic ee);
        exp_t e;
        @(posedge clk);
        #1;
        bus.ce       = ce;
        bus.op       = bank_op_e'(op);
        bus.new_bank = nb;
        bus.err_clr  = clr;
        e.due   = cyc + 1;
        e.name  = name;
        e.bank  = eb;
        e.level = el;
        e.err   = ee;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ce = 1'b0; bus.op = OP_NOP; bus.new_bank = '0; bus.err_clr = 1'b0;
        #12;
        chk_all("reset", 2'd0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // load range and error clear
        step("load2",    1, 3'd1, 2'd2, 0, 2'd2, 2'd0, 0);
        step("load3",    1, 3'd1, 2'd3, 0, 2'd2, 2'd0, 1);
        step("clr",      0, 3'd0, 2'd0, 1, 2'd2, 2'd0, 0);
        // wrap at MAX_BANK
        step("inc_wrap", 1, 3'd2, 2'd0, 0, 2'd0, 2'd0, 0);
        step("dec_wrap", 1, 3'd3, 2'd0, 0, 2'd2, 2'd0, 0);
        step("dec",      1, 3'd3, 2'd0, 0, 2'd1, 2'd0, 0);
        // ce=0 freezes everything, including illegal ops
        step("ce0_inc",  0, 3'd2, 2'd0, 0, 2'd1, 2'd0, 0);
        step("ce0_dec",  0, 3'd3, 2'd0, 0, 2'd1, 2'd0, 0);
        step("ce0_load", 0, 3'd1, 2'd0, 0, 2'd1, 2'd0, 0);
        step("ce0_rsv",  0, 3'd6, 2'd0, 0, 2'd1, 2'd0, 0);
        step("ce0_push", 0, 3'd4, 2'd2, 0, 2'd1, 2'd0, 0);
        // stack fill and drain
        step("push2",    1, 3'd4, 2'd2, 0, 2'd2, 2'd1, 0);
        step("push0",    1, 3'd4, 2'd0, 0, 2'd0, 2'd2, 0);
        step("push_ful", 1, 3'd4, 2'd1, 0, 2'd0, 2'd2, 1);
        step("clr2",     0, 3'd0, 2'd0, 1, 2'd0, 2'd2, 0);
        step("pop1",     1, 3'd5, 2'd0, 0, 2'd2, 2'd1, 0);
        step("pop2",     1, 3'd5, 2'd0, 0, 2'd1, 2'd0, 0);
        step("pop_emp",  1, 3'd5, 2'd0, 0, 2'd1, 2'd0, 1);
        step("clr3",     0, 3'd0, 2'd0, 1, 2'd1, 2'd0, 0);
        // illegal push operand and reserved opcodes
        step("push3",    1, 3'd4, 2'd3, 0, 2'd1, 2'd0, 1);
        step("clr4",     0, 3'd0, 2'd0, 1, 2'd1, 2'd0, 0);
        step("op6",      1, 3'd6, 2'd0, 0, 2'd1, 2'd0, 1);
        step("clr5",     0, 3'd0, 2'd0, 1, 2'd1, 2'd0, 0);
        step("op7",      1, 3'd7, 2'd0, 0, 2'd1, 2'd0, 1);
        step("clr6",     0, 3'd0, 2'd0, 1, 2'd1, 2'd0, 0);
        // set beats clear
        step("set_clr",  1, 3'd7, 2'd0, 1, 2'd1, 2'd0, 1);
        step("clr7",     0, 3'd0, 2'd0, 1, 2'd1, 2'd0, 0);
        // async reset mid-sequence
        step("push0b",   1, 3'd4, 2'd0, 0, 2'd0, 2'd1, 0);
        step("push2b",   1, 3'd4, 2'd2, 0, 2'd2, 2'd2, 0);
        step("hold",     0, 3'd0, 2'd0, 0, 2'd2, 2'd2, 0);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 2'd0, 2'd0, 1'b0);
        #1;
        rst = 1'b0;
        step("pop_after_rst", 1, 3'd5, 2'd0, 0, 2'd0, 2'd0, 1);
        step("clr8",          0, 3'd0, 2'd0, 1, 2'd0, 2'd0, 0);
        step("push1c",        1, 3'd4, 2'd1, 0, 2'd1, 2'd1, 0);
        step("pop_c",         1, 3'd5, 2'd0, 0, 2'd0, 2'd0, 0);
        step("idle",          0, 3'd0, 2'd0, 0, 2'd0, 2'd0, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bank_ctrl.md
Name: mem_bank_ctrl

Overview:
Parametrised successor to the simple bank register. Holds the current memory bank select for the CPU data path, and adds several operations: relative bank stepping with wrap, a bounded bank range, and a DEPTH-entry save/restore stack for call/interrupt bank context. Illegal requests raise a sticky error flag for the control unit.

Parameters:
WIDTH, 2, bank select width in bits.
MAX_BANK, 2**WIDTH-1, highest legal bank; range 0..2**WIDTH-1.
DEPTH, 4, save-stack entries; must be >= 1.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-high reset.
ce  in  1  operation enable; op is ignored when 0.
op  in  3  operation code, type bank_op_e.
new_bank  in  WIDTH  operand for LOAD/PUSH.
err_clr  in  1  clears err; acts independently of ce.
bank  out  WIDTH  current bank, registered.
level  out  $clog2(DEPTH+1)  number of occupied stack entries.
stack_full  out  1  level == DEPTH.
stack_empty  out  1  level == 0.
err  out  1  sticky error flag.

Behaviour:
- Reset is asynchronous, active-high, on clk/rst. Reset values: bank=0, level=0, stack_empty=1, stack_full=0, err=0. Stack contents are don't-care.
- All state changes occur on posedge clk.
- Latency:
  - Results of op appear on bank/level one cycle after the sampling edge.
  - stack_full/stack_empty derive combinationally from registered level.
- When ce=0: bank, level and stack hold. Only err_clr has effect.
- op encoding, acted on only when ce=1:
  - NOP=0: no change.
  - LOAD=1: if new_bank <= MAX_BANK, bank<=new_bank. Otherwise no change and err<=1.
  - INC=2: bank <= (bank==MAX_BANK) ? 0 : bank+1.
  - DEC=3: bank <= (bank==0) ? MAX_BANK : bank-1.
  - PUSH=4: legal only if !stack_full and new_bank <= MAX_BANK. When legal: stack[level]<=bank, level<=level+1, bank<=new_bank. When illegal: whole op suppressed (no partial update), err<=1.
  - POP=5: if !stack_empty, bank<=stack[level-1] and level<=level-1. Otherwise no change and err<=1.
  - 6, 7: reserved; no state change, err<=1.
- INC/DEC are always legal and never set err. Arithmetic wraps at MAX_BANK, not at 2**WIDTH.
- err:
  - Set on any illegal op listed above.
  - Cleared by err_clr=1.
  - If set and clear occur in the same cycle, set wins.
- PUSH at level DEPTH-1 succeeds and asserts stack_full on the next cycle. POP at level 1 succeeds and asserts stack_empty on the next cycle.
- Stack is strictly LIFO. No simultaneous push+pop op exists.
- Reset mid-sequence discards stack contents and level immediately. No pending effect survives reset.
- Inputs are sampled only at the clock edge. Outputs have no combinational path from op/new_bank.

Decomposition:
- Package mem_bank_pkg:
  - bank_op_e enum: NOP, LOAD, INC, DEC, PUSH, POP; 3-bit.
  - Helper function to compute wrapped next bank from (bank, MAX_BANK, dir).
- Sub-module mem_bank_lifo #(WIDTH, DEPTH):
  - Register-array stack with push/pop/level/full/empty.
  - Same async rst.
  - Instantiated once.
- mem_bank_ctrl contains:
  - Op decode.
  - Legality checks.
  - bank register.
  - err logic.

Test Plan:
All scenarios use WIDTH=2, MAX_BANK=2, DEPTH=2.
1. Reset then LOAD new_bank=2 with ce=1 -> bank=2 next cycle, err=0. LOAD 3 -> bank stays 2, err=1. err_clr=1 -> err=0.
2. bank=2, INC -> 0. DEC -> 2. DEC -> 1. Repeat with ce=0 -> bank unchanged throughout.
3. Stack fill and drain from bank=1:
   - PUSH 2 -> bank=2, level=1.
   - PUSH 0 -> bank=0, level=2, stack_full=1.
   - PUSH 1 -> no change, err=1.
   - POP -> bank=2, level=1.
   - POP -> bank=1, level=0, stack_empty=1.
   - POP -> err=1, bank=1.
4. PUSH with new_bank=3 at level 0 -> level stays 0, bank unchanged, err=1. op=6 and op=7 each set err with no state change.
5. Illegal op and err_clr=1 in the same cycle -> err=1.
6. After two PUSHes, assert rst mid-cycle (async) -> bank=0, level=0, stack_empty=1 immediately. Subsequent POP -> err=1.
